// File: rtl/pipe_mult_if.sv
// Issue/result handshake bundle between the RS issue port, the pipelined
// multiplier and the CDB arbiter. The multiplier connects as the slave.
interface pipe_mult_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic [TAG_W-1:0] in_T_idx;
    logic [XLEN-1:0]  in_regA;
    logic [XLEN-1:0]  in_regB;
    logic             in_ready;
    logic             out_valid;
    logic [TAG_W-1:0] out_T_idx;
    logic [XLEN-1:0]  out_result;
    logic             out_ready;

    modport master (
        output in_valid, in_T_idx, in_regA, in_regB, out_ready,
        input  in_ready, out_valid, out_T_idx, out_result
    );

    modport slave (
        input  in_valid, in_T_idx, in_regA, in_regB, out_ready,
        output in_ready, out_valid, out_T_idx, out_result
    );
endinterface

// File: rtl/pipe_mult.sv
// Pipelined low-half integer multiplier. Each stage multiplies the shifted
// operand A by one CH-bit chunk of B and accumulates into a running partial
// sum, so the last stage holds (A*B) mod 2^XLEN. The whole pipe stalls
// together under CDB back-pressure and a flush squashes every valid bit.
// The interface instance must be built with the same XLEN and TAG_W.
module pipe_mult #(
    parameter int XLEN      = 64,
    parameter int NUM_STAGE = 4,
    parameter int TAG_W     = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    pipe_mult_if.slave   bus,
    output logic         busy
);
    localparam int CH = XLEN / NUM_STAGE;
    localparam logic [XLEN-1:0] CHUNK_MASK = {XLEN{1'b1}} >> (XLEN - CH);

    logic [NUM_STAGE-1:0] valid_q;
    logic [NUM_STAGE-1:0] valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_STAGE];
    logic [TAG_W-1:0]     tag_d  [NUM_STAGE];
    logic [XLEN-1:0]      aSh_q  [NUM_STAGE];
    logic [XLEN-1:0]      aSh_d  [NUM_STAGE];
    logic [XLEN-1:0]      bRem_q [NUM_STAGE];
    logic [XLEN-1:0]      bRem_d [NUM_STAGE];
    logic [XLEN-1:0]      psum_q [NUM_STAGE];
    logic [XLEN-1:0]      psum_d [NUM_STAGE];

    logic advance;
    logic fireIn;

    assign advance        = ~valid_q[NUM_STAGE-1] | bus.out_ready;
    assign fireIn         = bus.in_valid & advance & ~flush;
    assign bus.in_ready   = advance & ~flush;
    assign bus.out_valid  = valid_q[NUM_STAGE-1] & ~flush;
    assign bus.out_T_idx  = tag_q[NUM_STAGE-1];
    assign bus.out_result = psum_q[NUM_STAGE-1];
    assign busy           = |valid_q;

    // Next-stage contents: stage 0 starts from the operands, later stages add one more B chunk
    always_comb begin
        valid_d   = '0;
        valid_d[0] = fireIn;
        tag_d[0]  = bus.in_T_idx;
        psum_d[0] = bus.in_regA * (bus.in_regB & CHUNK_MASK);
        aSh_d[0]  = bus.in_regA << CH;
        bRem_d[0] = bus.in_regB >> CH;
        for (int k = 1; k < NUM_STAGE; k++) begin
            valid_d[k] = valid_q[k-1];
            tag_d[k]   = tag_q[k-1];
            psum_d[k]  = psum_q[k-1] + aSh_q[k-1] * (bRem_q[k-1] & CHUNK_MASK);
            aSh_d[k]   = aSh_q[k-1] << CH;
            bRem_d[k]  = bRem_q[k-1] >> CH;
        end
    end

    // Stage registers: flush only kills valid bits, a stall freezes every stage at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                tag_q[k]  <= '0;
                aSh_q[k]  <= '0;
                bRem_q[k] <= '0;
                psum_q[k] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
            for (int k = 0; k < NUM_STAGE; k++) begin
                tag_q[k]  <= tag_d[k];
                aSh_q[k]  <= aSh_d[k];
                bRem_q[k] <= bRem_d[k];
                psum_q[k] <= psum_d[k];
            end
        end
    end
endmodule

// File: tb/tb_pipe_mult.sv
// Directed bench for pipe_mult: a 4-stage unit gets the directed sequences,
// 1-stage and 8-stage units get a random stream checked against A*B.
module tb_pipe_mult;
    logic clock = 1'b0;
    logic reset;
    logic flush4, flush1, flush8;
    logic busy4, busy1, busy8;
    int   vectors = 0;
    int   miscompares = 0;

    logic [63:0] opA [16];
    logic [63:0] opB [16];
    logic [5:0]  opT [16];
    logic [63:0] expR [16];

    pipe_mult_if #(.XLEN(64), .TAG_W(6)) bus4 ();
    pipe_mult_if #(.XLEN(64), .TAG_W(6)) bus1 ();
    pipe_mult_if #(.XLEN(64), .TAG_W(6)) bus8 ();

    pipe_mult #(.XLEN(64), .NUM_STAGE(4), .TAG_W(6)) dut4 (
        .clock(clock), .reset(reset), .flush(flush4), .bus(bus4), .busy(busy4));
    pipe_mult #(.XLEN(64), .NUM_STAGE(1), .TAG_W(6)) dut1 (
        .clock(clock), .reset(reset), .flush(flush1), .bus(bus1), .busy(busy1));
    pipe_mult #(.XLEN(64), .NUM_STAGE(8), .TAG_W(6)) dut8 (
        .clock(clock), .reset(reset), .flush(flush8), .bus(bus8), .busy(busy8));

    // Free-running clock, period 10
    always #5 clock = ~clock;

    // Watchdog so a wedged run still ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tagName, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tagName, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                                 input logic [5:0] t);
        bus4.in_valid = v;
        bus4.in_regA  = a;
        bus4.in_regB  = b;
        bus4.in_T_idx = t;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Issues n ops from the op tables back to back and checks results in order
    task automatic runStream(input int n, input int budget);
        int rd = 0;
        bus4.out_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (c < n) applyStimulus(1'b1, opA[c], opB[c], opT[c]);
            else       applyStimulus(1'b0, 64'd0, 64'd0, 6'd0);
            #1;
            if (c < n) checkOutput("stream_in_ready", 64'(bus4.in_ready), 64'd1);
            if (bus4.out_valid) begin
                if (rd < n) begin
                    checkOutput("stream_result", bus4.out_result, expR[rd]);
                    checkOutput("stream_tag", 64'(bus4.out_T_idx), 64'(opT[rd]));
                end
                rd++;
            end
            tick();
        end
        checkOutput("stream_count", 64'(rd), 64'(n));
    endtask

    initial begin
        int rd;
        int seen;
        int r1;
        int r8;
        reset  = 1'b1;
        flush4 = 1'b0;
        flush1 = 1'b0;
        flush8 = 1'b0;
        applyStimulus(1'b0, 64'd0, 64'd0, 6'd0);
        bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_regA = '0; bus1.in_regB = '0; bus1.in_T_idx = '0; bus1.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_regA = '0; bus8.in_regB = '0; bus8.in_T_idx = '0; bus8.out_ready = 1'b1;

        // Reset state
        #3;
        checkOutput("rst_in_ready", 64'(bus4.in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        checkOutput("rst_out_tag", 64'(bus4.out_T_idx), 64'd0);
        checkOutput("rst_out_result", bus4.out_result, 64'd0);
        checkOutput("rst_busy", 64'(busy4), 64'd0);
        checkOutput("rst_ns1_valid", 64'(bus1.out_valid), 64'd0);
        checkOutput("rst_ns8_busy", 64'(busy8), 64'd0);
        #9 reset = 1'b0;
        tick();

        // Single op 3*5 with tag 7, latency of NUM_STAGE register stages
        applyStimulus(1'b1, 64'd3, 64'd5, 6'd7);
        #1;
        checkOutput("single_in_ready", 64'(bus4.in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 64'd0, 64'd0, 6'd0);
        checkOutput("single_busy", 64'(busy4), 64'd1);
        checkOutput("single_early0", 64'(bus4.out_valid), 64'd0);
        tick();
        tick();
        checkOutput("single_early2", 64'(bus4.out_valid), 64'd0);
        tick();
        checkOutput("single_valid", 64'(bus4.out_valid), 64'd1);
        checkOutput("single_result", bus4.out_result, 64'd15);
        checkOutput("single_tag", 64'(bus4.out_T_idx), 64'd7);
        tick();
        checkOutput("single_retired", 64'(bus4.out_valid), 64'd0);
        checkOutput("single_idle", 64'(busy4), 64'd0);

        // Back-to-back: i * 0x1_0000_0001 = {i, i}
        for (int i = 0; i < 8; i++) begin
            opA[i]  = 64'(i);
            opB[i]  = 64'h0000_0001_0000_0001;
            opT[i]  = 6'(i);
            expR[i] = {32'(i), 32'(i)};
        end
        runStream(8, 14);

        // Truncation corners
        opA[0] = 64'hFFFF_FFFF_FFFF_FFFF; opB[0] = 64'd2; opT[0] = 6'd1; expR[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        opA[1] = 64'h8000_0000_0000_0000; opB[1] = 64'd2; opT[1] = 6'd2; expR[1] = 64'd0;
        opA[2] = 64'h0000_0001_0000_0000; opB[2] = 64'h0000_0001_0000_0000; opT[2] = 6'd3; expR[2] = 64'd0;
        opA[3] = 64'h1234; opB[3] = 64'h10; opT[3] = 6'd4; expR[3] = 64'h12340;
        runStream(4, 10);

        // Back-pressure: fill, stall 5 cycles, release
        for (int i = 0; i < 5; i++) begin
            opA[i]  = 64'(100 + i);
            opB[i]  = 64'd3;
            opT[i]  = 6'(10 + i);
            expR[i] = 64'(300 + 3 * i);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, opA[k], opB[k], opT[k]);
            tick();
        end
        bus4.out_ready = 1'b0;
        applyStimulus(1'b1, opA[4], opB[4], opT[4]);
        #1;
        for (int s = 0; s < 5; s++) begin
            checkOutput("stall_in_ready", 64'(bus4.in_ready), 64'd0);
            checkOutput("stall_out_valid", 64'(bus4.out_valid), 64'd1);
            checkOutput("stall_result", bus4.out_result, expR[0]);
            checkOutput("stall_tag", 64'(bus4.out_T_idx), 64'(opT[0]));
            tick();
        end
        bus4.out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 64'(bus4.in_ready), 64'd1);
        checkOutput("release_result", bus4.out_result, expR[0]);
        rd = 1;
        tick();
        applyStimulus(1'b0, 64'd0, 64'd0, 6'd0);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus4.out_valid) begin
                if (rd < 5) begin
                    checkOutput("drain_result", bus4.out_result, expR[rd]);
                    checkOutput("drain_tag", 64'(bus4.out_T_idx), 64'(opT[rd]));
                end
                rd++;
            end
            tick();
        end
        checkOutput("drain_count", 64'(rd), 64'd5);

        // Flush while a result is presented with out_ready high
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 64'(5 + k), 64'd5, 6'(20 + k));
            tick();
        end
        flush4 = 1'b1;
        #1;
        checkOutput("flushout_in_ready", 64'(bus4.in_ready), 64'd0);
        checkOutput("flushout_out_valid", 64'(bus4.out_valid), 64'd0);
        tick();
        flush4 = 1'b0;
        applyStimulus(1'b0, 64'd0, 64'd0, 6'd0);
        checkOutput("flushout_busy", 64'(busy4), 64'd0);

        // Flush with three ops in flight and a new op offered
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 64'(9 + k), 64'd2, 6'(30 + k));
            tick();
        end
        flush4 = 1'b1;
        #1;
        checkOutput("flush_in_ready", 64'(bus4.in_ready), 64'd0);
        tick();
        flush4 = 1'b0;
        applyStimulus(1'b0, 64'd0, 64'd0, 6'd0);
        checkOutput("flush_busy", 64'(busy4), 64'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus4.out_valid) seen++;
            tick();
        end
        checkOutput("flush_no_output", 64'(seen), 64'd0);
        opA[0] = 64'd7; opB[0] = 64'd6; opT[0] = 6'd9; expR[0] = 64'd42;
        runStream(1, 6);

        // Asynchronous reset between edges while a result is presented
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 64'(40 + k), 64'd7, 6'(40 + k));
            tick();
        end
        applyStimulus(1'b0, 64'd0, 64'd0, 6'd0);
        checkOutput("prereset_valid", 64'(bus4.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_out_valid", 64'(bus4.out_valid), 64'd0);
        checkOutput("areset_busy", 64'(busy4), 64'd0);
        checkOutput("areset_result", bus4.out_result, 64'd0);
        #1 reset = 1'b0;
        tick();
        checkOutput("postreset_valid", 64'(bus4.out_valid), 64'd0);

        // NUM_STAGE = 1 and 8 against the A*B reference
        opA[0] = 64'hFFFF_FFFF_FFFF_FFFF; opB[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        opA[1] = 64'h8000_0000_0000_0000; opB[1] = 64'd2;
        for (int i = 2; i < 10; i++) begin
            opA[i] = {$urandom(), $urandom()};
            opB[i] = {$urandom(), $urandom()};
        end
        for (int i = 0; i < 10; i++) begin
            opT[i]  = 6'(50 + i);
            expR[i] = opA[i] * opB[i];
        end
        r1 = 0;
        r8 = 0;
        for (int c = 0; c < 22; c++) begin
            bus1.in_valid = (c < 10);
            bus8.in_valid = (c < 10);
            if (c < 10) begin
                bus1.in_regA = opA[c]; bus1.in_regB = opB[c]; bus1.in_T_idx = opT[c];
                bus8.in_regA = opA[c]; bus8.in_regB = opB[c]; bus8.in_T_idx = opT[c];
            end
            #1;
            if (bus1.out_valid) begin
                if (r1 < 10) begin
                    checkOutput("ns1_result", bus1.out_result, expR[r1]);
                    checkOutput("ns1_tag", 64'(bus1.out_T_idx), 64'(opT[r1]));
                end
                r1++;
            end
            if (bus8.out_valid) begin
                if (r8 < 10) begin
                    checkOutput("ns8_result", bus8.out_result, expR[r8]);
                    checkOutput("ns8_tag", 64'(bus8.out_T_idx), 64'(opT[r8]));
                end
                r8++;
            end
            tick();
        end
        checkOutput("ns1_count", 64'(r1), 64'd10);
        checkOutput("ns8_count", 64'(r8), 64'd10);
        checkOutput("ns8_idle", 64'(busy8), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_mult.md
# pipe_mult

Parametrised, pipelined integer multiply functional unit that replaces the single-shot multiplier slot in the FU array. Each accepted operation carries a physical destination tag (T_idx) and returns the low XLEN bits of regA × regB after NUM_STAGE cycles. It sustains one issue per cycle, stalls globally under CDB back-pressure, and drops all in-flight work on a branch-mispredict flush. It sits between the RS issue port and the CDB arbiter.

## Interface
Parameters:
- XLEN, 64, operand and result width.
- NUM_STAGE, 4, pipeline depth. Must divide XLEN; legal values 1, 2, 4, 8.
- TAG_W, 6, width of the destination physical-register tag.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high. Clears all state immediately.
- flush  in  1  synchronous squash of every in-flight operation (mispredict rollback).
- in_valid  in  1  RS presents an operation.
- in_T_idx  in  TAG_W  destination tag.
- in_regA  in  XLEN  operand A (already muxed).
- in_regB  in  XLEN  operand B (register or zero-extended literal, already muxed).
- in_ready  out  1  unit can accept this cycle.
- out_valid  out  1  result available to the CDB.
- out_T_idx  out  TAG_W  tag of the presented result.
- out_result  out  XLEN  low XLEN bits of A×B.
- out_ready  in  1  CDB grants this unit this cycle.
- busy  out  1  at least one stage holds a valid operation.

## Operation
- CH = XLEN/NUM_STAGE. Stage k (1..NUM_STAGE) holds: valid, T_idx, A_sh (XLEN), B_rem (XLEN), psum (XLEN).
- Accept: fire_in = in_valid & in_ready & ~flush. Stage 1 loads:
  - psum = A × B[CH-1:0], truncated to XLEN;
  - A_sh = A << CH;
  - B_rem = B >> CH;
  - tag.
- Stage k+1 loads from stage k:
  - psum + A_sh × B_rem[CH-1:0], truncated to XLEN;
  - A_sh << CH;
  - B_rem >> CH;
  - tag and valid.
- The final stage's psum equals (A×B) mod 2^XLEN, so signed and unsigned inputs give identical low bits. No overflow flag.
- advance = ~valid[NUM_STAGE] | out_ready. When advance is 0, every stage holds (global stall, no bubble collapse).
- in_ready = advance & ~flush (combinational).
- out_valid = valid[NUM_STAGE] & ~flush. out_T_idx and out_result come directly from the stage-NUM_STAGE registers.
- Bubble: when advance = 1 and fire_in = 0, stage 1 valid loads 0. Data registers may load don't-care values, but the bench checks only valid-qualified outputs.
- Flush: at the next posedge all valid bits become 0, no input is accepted, and any result presented in the flush cycle is not committed even if out_ready = 1.
- busy = OR of all valid bits (registered state only).

## Timing
- Reset values: every valid = 0, every data and tag register = 0. Therefore in_ready = 1, out_valid = 0, out_T_idx = 0, out_result = 0, busy = 0.
- Latency: an operation accepted at posedge t is presented (out_valid = 1) after posedge t+NUM_STAGE-1, i.e. NUM_STAGE cycles of register delay, when there are no stalls.
- Throughput: one operation per cycle while out_ready is held at 1.
- Stall: out_valid = 1 with out_ready = 0 freezes all stages and drives in_ready = 0. Outputs stay stable until out_ready = 1.
- Simultaneous flush and out_ready: flush wins and the result is dropped.
- Simultaneous flush and in_valid: the input is ignored and in_ready = 0.
- Full pipe with out_ready = 1: output retires and input is accepted in the same cycle, with no gap.
- Reset asserted mid-operation: all in-flight work is lost immediately, with no partial output.
- NUM_STAGE = 1: degenerates to a single-register multiplier with psum = A×B.

## Test plan
- Reset, then one op with A = 3, B = 5, tag = 7, out_ready = 1 → out_valid rises exactly 4 cycles after accept with result 15, tag 7; busy drops the following cycle.
- Back-to-back issue: 8 ops, A = i, B = 0x1_0000_0001, tags 0..7 → results i×0x1_0000_0001 in order, one per cycle, in_ready held at 1.
- Wrap/truncation: A = 0xFFFF_FFFF_FFFF_FFFF, B = 2 → result 0xFFFF_FFFF_FFFF_FFFE. A = 0x8000_0000_0000_0000, B = 2 → result 0.
- Back-pressure: fill the pipe, hold out_ready = 0 for 5 cycles → in_ready = 0, outputs frozen on the first result; release → remaining results retire in order with none lost or duplicated.
- Flush with 3 ops in flight and in_valid = 1 → in_ready = 0 that cycle, no out_valid afterward, busy = 0 next cycle; a new op issued afterward completes normally.
- Asynchronous reset pulse mid-stream (between clock edges) → out_valid, busy = 0 immediately. Repeat all checks for NUM_STAGE = 1 and NUM_STAGE = 8 with random operands against a reference model (low 64 bits).
